// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the datapath/memory side.
// The master modport is the controller; the slave modport is the datapath.
interface multicycle_controller_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          instruction;
    logic                c;
    logic                z;
    logic                mem_ready;
    logic                ir_load;
    logic                pc_write;
    logic [3:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_const;
    logic [1:0]          cin_sel;
    logic                mem_read;
    logic                mem_write;
    logic                rf_write;
    logic [2:0]          rf_in_sel;
    logic                rf_read2_rd;
    logic                push_stack;
    logic                pop_stack;
    logic                busy;
    logic                fault;
    logic [1:0]          fault_code;

    modport master (
        input  instruction, c, z, mem_ready,
        output ir_load, pc_write, pc_src, alu_op, alu_src_const,
        output cin_sel, mem_read, mem_write, rf_write, rf_in_sel,
        output rf_read2_rd, push_stack, pop_stack, busy, fault, fault_code
    );

    modport slave (
        output instruction, c, z, mem_ready,
        input  ir_load, pc_write, pc_src, alu_op, alu_src_const,
        input  cin_sel, mem_read, mem_write, rf_write, rf_in_sel,
        input  rf_read2_rd, push_stack, pop_stack, busy, fault, fault_code
    );
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM with return-stack and memory-timeout faults.
// Define MC_CTRL_PERF_EN to add saturating cycle_count/retire_count outputs.
module multicycle_controller #(
    parameter int ALU_OP_W    = 4,
    parameter int STACK_DEPTH = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    multicycle_controller_if.master bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count
`endif
);

    localparam int OCC_W = $clog2(STACK_DEPTH + 1);
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_SHIFT, CL_LDM, CL_STM,
        CL_BR, CL_JMP, CL_JSB, CL_RET, CL_NOP
    } op_class_e;

    state_e             state_q, state_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               fault_q, fault_d;
    logic [1:0]         fcode_q, fcode_d;

    op_class_e          cls;
    logic               taken;
    logic               is_ldm;
    logic [TMO_W:0]     tmo_inc;
    logic               timed_out;

    logic                ir_load, pc_write, alu_src_const;
    logic                mem_read, mem_write, rf_write, rf_read2_rd;
    logic                push_stack, pop_stack, busy;
    logic [3:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          cin_sel;
    logic [2:0]          rf_in_sel;

    always_comb begin
        cls = CL_NOP;
        casez (bus.instruction)
            6'b00????: cls = CL_ALU_R;
            6'b01????: cls = CL_ALU_I;
            6'b100???: cls = CL_SHIFT;
            6'b101000: cls = CL_LDM;
            6'b101001: cls = CL_STM;
            6'b110???: cls = CL_BR;
            6'b111000: cls = CL_JMP;
            6'b111001: cls = CL_JSB;
            6'b111010: cls = CL_RET;
            default:   cls = CL_NOP;
        endcase
    end

    always_comb begin
        unique case (bus.instruction[2:1])
            2'b00:   taken = bus.z;
            2'b01:   taken = !bus.z;
            2'b10:   taken = bus.c;
            default: taken = !bus.c;
        endcase
    end

    assign is_ldm    = (cls == CL_LDM);
    assign tmo_inc   = {1'b0, tmo_q} + 1'b1;
    // a ready in the final allowed cycle takes priority over the timeout
    assign timed_out = (MEM_TIMEOUT != 0) &&
                       (tmo_inc == (TMO_W + 1)'(MEM_TIMEOUT));

    always_comb begin
        state_d       = state_q;
        occ_d         = occ_q;
        tmo_d         = tmo_q;
        fault_d       = fault_q;
        fcode_d       = fcode_q;
        ir_load       = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 4'b0000;
        alu_op        = '0;
        alu_src_const = 1'b0;
        cin_sel       = 2'b00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        rf_write      = 1'b0;
        rf_in_sel     = 3'b000;
        rf_read2_rd   = 1'b0;
        push_stack    = 1'b0;
        pop_stack     = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    busy    = 1'b1;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    busy = 1'b1;
                    unique case (cls)
                        CL_ALU_R, CL_ALU_I: begin
                            alu_op        = ALU_OP_W'({1'b0, bus.instruction[3:1]});
                            alu_src_const = (cls == CL_ALU_I);
                            cin_sel       = 2'b01;
                            state_d       = S_WB;
                        end
                        CL_SHIFT: begin
                            cin_sel = 2'b10;
                            state_d = S_WB;
                        end
                        CL_LDM, CL_STM: begin
                            alu_src_const = 1'b1;
                            tmo_d         = '0;
                            state_d       = S_MEM;
                        end
                        CL_BR: begin
                            pc_write = 1'b1;
                            pc_src   = taken ? 4'b0010 : 4'b0001;
                            state_d  = S_FETCH;
                        end
                        CL_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = 4'b0100;
                            state_d  = S_FETCH;
                        end
                        CL_JSB: begin
                            if (occ_q < OCC_W'(STACK_DEPTH)) begin
                                push_stack = 1'b1;
                                pc_write   = 1'b1;
                                pc_src     = 4'b0100;
                                occ_d      = occ_q + OCC_W'(1);
                                state_d    = S_FETCH;
                            end else begin
                                fault_d = 1'b1;
                                fcode_d = 2'b01;
                                state_d = S_FAULT;
                            end
                        end
                        CL_RET: begin
                            if (occ_q != '0) begin
                                pop_stack = 1'b1;
                                pc_write  = 1'b1;
                                pc_src    = 4'b1000;
                                occ_d     = occ_q - OCC_W'(1);
                                state_d   = S_FETCH;
                            end else begin
                                fault_d = 1'b1;
                                fcode_d = 2'b10;
                                state_d = S_FAULT;
                            end
                        end
                        default: begin
                            pc_write = 1'b1;
                            pc_src   = 4'b0001;
                            state_d  = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    busy        = 1'b1;
                    mem_read    = is_ldm;
                    mem_write   = !is_ldm;
                    rf_read2_rd = !is_ldm;
                    if (bus.mem_ready) begin
                        if (is_ldm) begin
                            state_d = S_WB;
                        end else begin
                            pc_write = 1'b1;
                            pc_src   = 4'b0001;
                            state_d  = S_FETCH;
                        end
                    end else if (timed_out) begin
                        fault_d = 1'b1;
                        fcode_d = 2'b11;
                        state_d = S_FAULT;
                    end else begin
                        tmo_d = tmo_inc[TMO_W-1:0];
                    end
                end
                S_WB: begin
                    busy      = 1'b1;
                    rf_write  = 1'b1;
                    rf_in_sel = is_ldm ? 3'b010 :
                                (cls == CL_SHIFT) ? 3'b100 : 3'b001;
                    pc_write  = 1'b1;
                    pc_src    = 4'b0001;
                    state_d   = S_FETCH;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            occ_q   <= '0;
            tmo_q   <= '0;
            fault_q <= 1'b0;
            fcode_q <= 2'b00;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            fcode_q <= fcode_d;
        end
    end

    assign bus.ir_load       = ir_load;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src        = pc_src;
    assign bus.alu_op        = alu_op;
    assign bus.alu_src_const = alu_src_const;
    assign bus.cin_sel       = cin_sel;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.rf_write      = rf_write;
    assign bus.rf_in_sel     = rf_in_sel;
    assign bus.rf_read2_rd   = rf_read2_rd;
    assign bus.push_stack    = push_stack;
    assign bus.pop_stack     = pop_stack;
    assign bus.busy          = busy;
    assign bus.fault         = fault_q;
    assign bus.fault_code    = fcode_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (state_q != S_FAULT && cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (pc_write && ret_q != '1)            ret_d = ret_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;
`endif

endmodule
